// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and constants for the data-memory wait-state controller:
//   FSM state encoding, latched operation type, data/counter widths and
//   the parity helper used when DMEM_PARITY_EN is defined.
package dmem_pkg;

    localparam int DWORD_W = 64;   // storage word / bus width
    localparam int CNT_W   = 4;    // wait-state counter width (0..15)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dmem_op_e;

    // Even parity over one doubleword.
    function automatic logic dword_parity(input logic [DWORD_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// dmem_wait_ctrl_if
//   MEM-stage request/handshake bundle between the pipeline (master) and the
//   data-memory controller (slave).
//   d_mem_we / d_mem_re / d_mem_addr : request, held stable while stall=1
//   stall                            : freeze IF..MEM pipeline registers
//   rd_valid                         : read data valid on the data bus
//   req_err                          : we and re asserted together
//   par_err (DMEM_PARITY_EN only)    : parity mismatch on the returned read
//   The bidirectional 64-bit data bus is a plain module port so that the
//   tri-state resolution stays at the module boundary.
interface dmem_wait_ctrl_if #(parameter int ADDR_BITS = 6);

    logic                 d_mem_we;
    logic                 d_mem_re;
    logic [ADDR_BITS-1:0] d_mem_addr;
    logic                 stall;
    logic                 rd_valid;
    logic                 req_err;

`ifdef DMEM_PARITY_EN
    logic                 par_err;

    modport master (output d_mem_we, d_mem_re, d_mem_addr,
                    input  stall, rd_valid, req_err, par_err);
    modport slave  (input  d_mem_we, d_mem_re, d_mem_addr,
                    output stall, rd_valid, req_err, par_err);
`else
    modport master (output d_mem_we, d_mem_re, d_mem_addr,
                    input  stall, rd_valid, req_err);
    modport slave  (input  d_mem_we, d_mem_re, d_mem_addr,
                    output stall, rd_valid, req_err);
`endif

endinterface

// File: rtl/dmem_array.sv
// dmem_array
//   Doubleword storage, DEPTH = 2**ADDR_BITS entries of DWORD_W bits.
//   Synchronous write, registered read; contents are never reset.
//   Ports:
//     clk      clock
//     we       commit wdata to addr on this edge
//     re       register mem[addr] into rdata on this edge
//     addr     doubleword index
//     wdata    write data
//     rdata    registered read data
//     par_err  (DMEM_PARITY_EN) registered parity mismatch of the last read
//   Macro DMEM_PARITY_EN adds one parity bit per entry and the flip_parity
//   hook task used to inject a corruption from a testbench.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DWORD_W-1:0]   wdata,
`ifdef DMEM_PARITY_EN
    output logic                 par_err,
`endif
    output logic [DWORD_W-1:0]   rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DWORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[addr] <= dword_parity(wdata);
        end
        if (re) begin
            par_err <= dword_parity(mem[addr]) ^ par_mem[addr];
        end
    end

    // Injects a single-bit parity corruption into one entry.
    task automatic flip_parity(input logic [ADDR_BITS-1:0] a);
        par_mem[a] <= ~par_mem[a];
    endtask
`endif

endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl
//   Data-memory partner of the MEM stage. Accepts one read or write at a
//   time, holds the pipeline with stall for WAIT_CYCLES extra cycles and
//   completes the access in a RESP cycle (stall=0) so the pipeline advances
//   on the RESP edge.
//   Ports:
//     clk         clock, all state on posedge
//     rst_n       synchronous active-low reset
//     bus         dmem_wait_ctrl_if.slave (request, stall, rd_valid, req_err,
//                 par_err when DMEM_PARITY_EN is defined)
//     d_mem_data  bidirectional data: write data in, read data out in RESP
//   Parameters: ADDR_BITS (index width), WAIT_CYCLES (0..15).
//   Macro DMEM_PARITY_EN enables per-entry parity and the par_err output.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_wait_ctrl_if.slave    bus,
    inout  wire  [DWORD_W-1:0] d_mem_data
);

    dmem_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    dmem_op_e             op_q, op_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DWORD_W-1:0]   wdata_q;

    logic                 req;
    logic                 accept;
    logic                 enter_resp;
    logic                 rd_drive;
    logic                 arr_we, arr_re;
    logic [ADDR_BITS-1:0] arr_addr;
    logic [DWORD_W-1:0]   arr_wdata, arr_rdata;

    assign req = bus.d_mem_we | bus.d_mem_re;

    // Control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Request capture; datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.d_mem_addr;
            wdata_q <= d_mem_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        accept    = 1'b0;
        bus.stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    bus.stall = 1'b1;
                    // write wins when both are requested
                    op_d      = bus.d_mem_we ? OP_WRITE : OP_READ;
                    cnt_d     = CNT_W'(WAIT_CYCLES);
                    state_d   = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                bus.stall = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // old request is still on the bus here; never re-accept it
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RESP is always followed by IDLE, so state_d==RESP means "entering RESP".
    assign enter_resp = (state_d == RESP);

    // With zero wait states the access is entered straight from IDLE, before
    // the latches hold anything, so the live request is used there.
    assign arr_addr  = (state_q == IDLE) ? bus.d_mem_addr : addr_q;
    assign arr_wdata = (state_q == IDLE) ? d_mem_data     : wdata_q;

    // Reset on the entering edge aborts the access: nothing is committed.
    assign arr_we = rst_n & enter_resp & (op_d == OP_WRITE);
    assign arr_re = rst_n & enter_resp & (op_d == OP_READ);

    assign rd_drive     = (state_q == RESP) && (op_q == OP_READ);
    assign bus.rd_valid = rd_drive;
    assign bus.req_err  = (state_q == IDLE) & bus.d_mem_we & bus.d_mem_re;
    assign d_mem_data   = rd_drive ? arr_rdata : {DWORD_W{1'bz}};

`ifdef DMEM_PARITY_EN
    logic arr_par_err;
    assign bus.par_err = rd_drive & arr_par_err;
`endif

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .re      (arr_re),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
`ifdef DMEM_PARITY_EN
        .par_err (arr_par_err),
`endif
        .rdata   (arr_rdata)
    );

endmodule
